// File: rtl/vx_tcu_fedp_seq_if.sv
// Job / operand / result handshakes between the TCU operand collector and the FEDP issue sequencer.
// The master modport is the collector side; the slave modport is the sequencer side.
interface vx_tcu_fedp_seq_if #(
  parameter int N     = 2,
  parameter int XLEN  = 32,
  parameter int STEPW = 5
);
  logic                job_valid;
  logic                job_ready;
  logic [2:0]          job_fmt_s;
  logic [STEPW-1:0]    job_steps;
  logic [XLEN-1:0]     job_c;
  logic                op_valid;
  logic                op_ready;
  logic [N*XLEN-1:0]   op_a;
  logic [N*XLEN-1:0]   op_b;
  logic                res_valid;
  logic                res_ready;
  logic [XLEN-1:0]     res_data;

  modport master (
    output job_valid, job_fmt_s, job_steps, job_c, op_valid, op_a, op_b, res_ready,
    input  job_ready, op_ready, res_valid, res_data
  );

  modport slave (
    input  job_valid, job_fmt_s, job_steps, job_c, op_valid, op_a, op_b, res_ready,
    output job_ready, op_ready, res_valid, res_data
  );
endinterface

// File: rtl/vx_tcu_fedp_seq.sv
// FEDP issue sequencer: per K-step 1 ISSUE cycle + LATENCY+1 WAIT cycles, stalls on op_valid/res_ready low.
// Define VX_TCU_FEDP_SEQ_PERF_EN to add the perf_jobs / perf_stall counters.
module vx_tcu_fedp_seq #(
  parameter int N         = 2,
  parameter int XLEN      = 32,
  parameter int LATENCY   = 4,
  parameter int MAX_STEPS = 16,
  parameter int STEPW     = $clog2(MAX_STEPS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  vx_tcu_fedp_seq_if.slave  bus,
  output logic              fedp_enable,
  output logic [2:0]        fedp_fmt_s,
  output logic [N*XLEN-1:0] fedp_a_row,
  output logic [N*XLEN-1:0] fedp_b_col,
  output logic [XLEN-1:0]   fedp_c_val,
  input  logic [XLEN-1:0]   fedp_d_val,
`ifdef VX_TCU_FEDP_SEQ_PERF_EN
  output logic [31:0]       perf_jobs,
  output logic [31:0]       perf_stall,
`endif
  output logic              busy
);
  localparam int CNTW = $clog2(LATENCY + 1);
  localparam logic [CNTW-1:0] LAT = CNTW'(LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state, state_n;
  logic [STEPW-1:0]  remaining;
  logic [CNTW-1:0]   cnt;
  logic [XLEN-1:0]   acc;
  logic              fmt_ok;
  logic              job_ready, op_ready, res_valid;

  assign fmt_ok        = (fedp_fmt_s == 3'd2) || (fedp_fmt_s == 3'd3);
  assign bus.job_ready = job_ready;
  assign bus.op_ready  = op_ready;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = acc;
  assign fedp_c_val    = acc;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    job_ready   = 1'b0;
    op_ready    = 1'b0;
    res_valid   = 1'b0;
    fedp_enable = 1'b0;
    case (state)
      IDLE: begin
        job_ready = 1'b1;
        if (bus.job_valid) state_n = (bus.job_steps == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        op_ready    = 1'b1;
        fedp_enable = 1'b1;
        if (bus.op_valid) state_n = WAIT;
      end
      WAIT: begin
        fedp_enable = 1'b1;
        if (cnt == LAT) state_n = (remaining != '0) ? ISSUE : DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (bus.res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Capture at cnt==LATENCY: the pipeline has been enabled LATENCY times since launch,
  // so anything left over from an earlier or abandoned job has already been shifted out.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      remaining  <= '0;
      cnt        <= '0;
      fedp_fmt_s <= '0;
      fedp_a_row <= '0;
      fedp_b_col <= '0;
    end else begin
      case (state)
        IDLE: if (bus.job_valid) begin
          fedp_fmt_s <= bus.job_fmt_s;
          remaining  <= bus.job_steps;
          acc        <= XLEN'(bus.job_c[31:0]);
        end
        ISSUE: if (bus.op_valid) begin
          fedp_a_row <= bus.op_a;
          fedp_b_col <= bus.op_b;
          remaining  <= remaining - 1'b1;
          cnt        <= '0;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAT) acc <= fmt_ok ? XLEN'(fedp_d_val[31:0]) : XLEN'(32'h7FC00000);
        end
        default: ;
      endcase
    end
  end

`ifdef VX_TCU_FEDP_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_jobs  <= '0;
      perf_stall <= '0;
    end else begin
      if (res_valid && bus.res_ready) perf_jobs <= perf_jobs + 32'd1;
      if ((state == ISSUE && !bus.op_valid) || (state == DONE && !bus.res_ready))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_tcu_fedp_seq.sv
// Directed bench for vx_tcu_fedp_seq with a behavioural FEDP (enabled LATENCY-stage pipeline) attached.
module tb_vx_tcu_fedp_seq;
  localparam int N = 2, XLEN = 32, LATENCY = 4, MAX_STEPS = 16;
  localparam int STEPW = $clog2(MAX_STEPS + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic              fedp_enable;
  logic [2:0]        fedp_fmt_s;
  logic [N*XLEN-1:0] fedp_a_row, fedp_b_col;
  logic [XLEN-1:0]   fedp_c_val, fedp_d_val;
  logic              busy;
  logic [31:0]       perf_jobs, perf_stall;
  int total = 0;
  int bad = 0;
  int beats = 0;
  int en_cycles = 0;

  vx_tcu_fedp_seq_if #(.N(N), .XLEN(XLEN), .STEPW(STEPW)) bus ();

  vx_tcu_fedp_seq #(.N(N), .XLEN(XLEN), .LATENCY(LATENCY), .MAX_STEPS(MAX_STEPS)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .fedp_enable(fedp_enable), .fedp_fmt_s(fedp_fmt_s),
    .fedp_a_row(fedp_a_row), .fedp_b_col(fedp_b_col),
    .fedp_c_val(fedp_c_val), .fedp_d_val(fedp_d_val),
`ifdef VX_TCU_FEDP_SEQ_PERF_EN
    .perf_jobs(perf_jobs), .perf_stall(perf_stall),
`endif
    .busy(busy)
  );

`ifndef VX_TCU_FEDP_SEQ_PERF_EN
  assign perf_jobs  = '0;
  assign perf_stall = '0;
`endif

  always #5 clk = ~clk;

  function automatic real pow2(input int e);
    real p = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) p = p * 2.0;
    else        for (int i = 0; i < -e; i++) p = p / 2.0;
    return p;
  endfunction

  function automatic real h2r(input logic [15:0] h, input logic [2:0] fmt);
    int e, m;
    real v;
    if (fmt == 3'd3) begin e = int'(h[14:7]);  m = int'(h[6:0]); v = 1.0 + real'(m) / 128.0;  e = e - 127; end
    else             begin e = int'(h[14:10]); m = int'(h[9:0]); v = 1.0 + real'(m) / 1024.0; e = e - 15; end
    if ((fmt == 3'd3 && h[14:7] == 8'd0) || (fmt != 3'd3 && h[14:10] == 5'd0)) return 0.0;
    v = v * pow2(e);
    return h[15] ? -v : v;
  endfunction

  function automatic real f2r(input logic [31:0] f);
    real v;
    if (f[30:23] == 8'd0) return 0.0;
    v = (1.0 + real'(int'(f[22:0])) / 8388608.0) * pow2(int'(f[30:23]) - 127);
    return f[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [31:0] fedp_dot(input logic [N*XLEN-1:0] a, input logic [N*XLEN-1:0] b,
                                           input logic [31:0] c, input logic [2:0] fmt);
    real s;
    s = f2r(c);
    for (int i = 0; i < 2 * N; i++) s = s + h2r(a[i*16 +: 16], fmt) * h2r(b[i*16 +: 16], fmt);
    return r2f(s);
  endfunction

  // Attached FEDP: handshake-free, advances only while enabled.
  logic [31:0] pipe [LATENCY];
  always @(posedge clk) begin
    if (fedp_enable) begin
      pipe[0] <= fedp_dot(fedp_a_row, fedp_b_col, fedp_c_val[31:0], fedp_fmt_s);
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign fedp_d_val = XLEN'(pipe[LATENCY-1]);

  always @(posedge clk) begin
    if (bus.op_valid && bus.op_ready) beats <= beats + 1;
    if (fedp_enable) en_cycles <= en_cycles + 1;
  end

  task automatic set_ops(input logic [15:0] ha, input logic [15:0] hb);
    bus.op_a = {2*N{ha}};
    bus.op_b = {2*N{hb}};
  endtask

  task automatic start_job(input logic [2:0] fmt, input int steps, input logic [31:0] c);
    @(negedge clk);
    bus.job_fmt_s = fmt;
    bus.job_steps = STEPW'(steps);
    bus.job_c     = c;
    bus.job_valid = 1'b1;
    @(posedge clk);
    #1 bus.job_valid = 1'b0;
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.res_valid) return;
    end
    cyc = -1;
  endtask

  task automatic take_res;
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++; if (bus.job_ready !== 1'b1) begin bad++; $display("FAIL rst_job_ready got=%b want=1", bus.job_ready); end
    total++; if (bus.op_ready !== 1'b0) begin bad++; $display("FAIL rst_op_ready got=%b want=0", bus.op_ready); end
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b want=0", bus.res_valid); end
    total++; if (fedp_enable !== 1'b0) begin bad++; $display("FAIL rst_fedp_enable got=%b want=0", fedp_enable); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (bus.res_data !== '0 || fedp_c_val !== '0) begin bad++; $display("FAIL rst_acc res=%h c=%h want=0", bus.res_data, fedp_c_val); end
    total++; if (fedp_a_row !== '0 || fedp_b_col !== '0 || fedp_fmt_s !== 3'd0) begin
      bad++; $display("FAIL rst_operands a=%h b=%h fmt=%0d want=0", fedp_a_row, fedp_b_col, fedp_fmt_s); end
  endtask

  task automatic test_fp16;
    int cyc;
    set_ops(16'h3C00, 16'h3C00);
    bus.op_valid = 1'b1;
    start_job(3'd2, 2, 32'h3F800000);
    wait_res(cyc);
    total++; if (cyc !== 13) begin bad++; $display("FAIL fp16_latency got=%0d want=13", cyc); end
    total++; if (bus.res_data !== 32'h41100000) begin bad++; $display("FAIL fp16_data got=%h want=41100000", bus.res_data); end
    take_res();
  endtask

  task automatic test_bf16_op_stall;
    int cyc, b0;
    set_ops(16'h4000, 16'h3F80);
    bus.op_valid = 1'b0;
    b0 = beats;
    start_job(3'd3, 1, 32'h0);
    repeat (5) @(negedge clk);
    total++; if (bus.op_ready !== 1'b1 || fedp_enable !== 1'b1 || beats !== b0) begin
      bad++; $display("FAIL op_stall op_ready=%b en=%b beats=%0d want 1 1 %0d", bus.op_ready, fedp_enable, beats, b0); end
    bus.op_valid = 1'b1;
    wait_res(cyc);
    total++; if (bus.res_data !== 32'h41000000) begin bad++; $display("FAIL bf16_data got=%h want=41000000", bus.res_data); end
    take_res();
  endtask

  task automatic test_steps_zero;
    int cyc, b0, e0;
    b0 = beats; e0 = en_cycles;
    start_job(3'd2, 0, 32'h40490FDB);
    wait_res(cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL zero_latency got=%0d want=1", cyc); end
    total++; if (bus.res_data !== 32'h40490FDB) begin bad++; $display("FAIL zero_data got=%h want=40490fdb", bus.res_data); end
    total++; if (beats !== b0 || en_cycles !== e0) begin
      bad++; $display("FAIL zero_side_effect beats=%0d en=%0d want=0 0", beats - b0, en_cycles - e0); end
    take_res();
  endtask

  task automatic test_bad_fmt;
    int cyc, b0;
    set_ops(16'h3C00, 16'h3C00);
    b0 = beats;
    start_job(3'd5, 3, 32'h3F800000);
    wait_res(cyc);
    total++; if (beats - b0 !== 3) begin bad++; $display("FAIL badfmt_beats got=%0d want=3", beats - b0); end
    total++; if (bus.res_data !== 32'h7FC00000) begin bad++; $display("FAIL badfmt_data got=%h want=7fc00000", bus.res_data); end
    total++; if (cyc !== 19) begin bad++; $display("FAIL badfmt_latency got=%0d want=19", cyc); end
    take_res();
  endtask

  task automatic test_back_to_back;
    int cyc, stall_bad;
    logic [31:0] s0, j0;
    set_ops(16'h3C00, 16'h3C00);
    start_job(3'd2, 1, 32'h3F800000);
    wait_res(cyc);
    total++; if (bus.res_data !== 32'h40A00000) begin bad++; $display("FAIL b2b_first got=%h want=40a00000", bus.res_data); end
    s0 = perf_stall; j0 = perf_jobs;
    bus.job_fmt_s = 3'd2; bus.job_steps = '0; bus.job_c = 32'h12345678; bus.job_valid = 1'b1;
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.res_data !== 32'h40A00000 || bus.job_ready !== 1'b0 || bus.res_valid !== 1'b1) stall_bad++;
    end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL res_hold bad_cycles=%0d want=0", stall_bad); end
`ifdef VX_TCU_FEDP_SEQ_PERF_EN
    total++; if (perf_stall - s0 !== 32'd10) begin bad++; $display("FAIL perf_stall delta=%0d want=10", perf_stall - s0); end
`endif
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    @(posedge clk);
    #1 bus.job_valid = 1'b0;
    wait_res(cyc);
    total++; if (cyc !== 1 || bus.res_data !== 32'h12345678) begin
      bad++; $display("FAIL b2b_second cyc=%0d data=%h want 1 12345678", cyc, bus.res_data); end
`ifdef VX_TCU_FEDP_SEQ_PERF_EN
    total++; if (perf_jobs - j0 !== 32'd1) begin bad++; $display("FAIL perf_jobs delta=%0d want=1", perf_jobs - j0); end
`endif
    take_res();
  endtask

  task automatic test_reset_mid_job;
    int cyc;
    set_ops(16'h3C00, 16'h3C00);
    start_job(3'd2, 1, 32'h0);
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b1 || fedp_enable !== 1'b1 || bus.op_ready !== 1'b0) begin
      bad++; $display("FAIL midjob_in_wait busy=%b en=%b op_ready=%b want 1 1 0", busy, fedp_enable, bus.op_ready); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || bus.job_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL midjob_reset busy=%b job_ready=%b res_valid=%b want 0 1 0", busy, bus.job_ready, bus.res_valid); end
    set_ops(16'h4000, 16'h4000);
    start_job(3'd3, 1, 32'h3F800000);
    wait_res(cyc);
    total++; if (bus.res_data !== 32'h41880000) begin bad++; $display("FAIL midjob_next got=%h want=41880000", bus.res_data); end
    take_res();
  endtask

  initial begin
    bus.job_valid = 1'b0; bus.job_fmt_s = '0; bus.job_steps = '0; bus.job_c = '0;
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_fp16();
    test_bf16_op_stall();
    test_steps_zero();
    test_bad_fmt();
    test_back_to_back();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
